rv32i_control_fsm: RTL
======================

# rv32i_control_fsm

Multi-cycle sequencer for the von Neumann RV32I core. It uses the decoder's opCode, funct3, rg_we and rd_addr outputs to step each instruction through fetch, decode, execute, memory and writeback. A single shared memory port serves both instruction fetch and data access, and the block arbitrates that port. It drives every datapath select and enable (IR, PC, ALU operands, register file write), detects illegal and misaligned operations, and counts retired instructions.

## Interface
- MEM_TIMEOUT, 255: maximum cycles mem_req may wait for mem_ready before trapping (1..255)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; forces state FETCH, counters 0, illegal/halted 0
- opCode  in  7  decoder opcode (combinational from IR)
- funct3  in  3  decoder funct3
- rg_we  in  1  decoder register-write enable
- rd_addr  in  5  decoder destination register
- branch_taken  in  1  ALU compare result, valid in EXECUTE
- addr_lo  in  2  ALU result bits [1:0], valid in EXECUTE and MEM
- mem_ready  in  1  memory completion strobe for the current request
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  1 = store
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- mem_wstrb  out  4  byte enables for stores, 0 otherwise
- ir_we  out  1  latch instruction register
- pc_we  out  1  update PC
- pc_sel  out  2  0 = PC+4, 1 = PC+imm, 2 = ALU & ~1
- alu_a_sel  out  1  0 = rs1, 1 = PC
- alu_b_sel  out  1  0 = rs2, 1 = immediate
- rf_we  out  1  register file write
- rf_wsel  out  2  0 = ALU, 1 = load data, 2 = PC+4, 3 = immediate
- illegal  out  1  sticky: illegal opcode, misaligned access or timeout
- halted  out  1  high in TRAP
- retired  out  32  count of completed instructions
- state  out  3  debug: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=5

## Operation
- All outputs are decoded combinationally from state and inputs. While reset is high, every output is 0.
- FETCH: mem_req=1, mem_addr_sel=0. When mem_ready is high: ir_we=1, next state DECODE.
- DECODE: one cycle for register-file read. Opcode is checked here; an opcode not in the RV32I base set goes to TRAP with illegal=1. Otherwise the next state is EXECUTE.
- EXECUTE, by opcode:
  - LUI: alu_b_sel=1, then WB with rf_wsel=3.
  - AUIPC: alu_a_sel=1, alu_b_sel=1, then WB with rf_wsel=0.
  - JAL / JALR: rf_wsel=2 in WB. pc_sel is 1 for JAL and 2 for JALR.
  - OP-IMM: alu_b_sel=1. OP: alu_b_sel=0. Both go to WB with rf_wsel=0.
  - Branch: pc_we=1 in EXECUTE, pc_sel = branch_taken ? 1 : 0, next state FETCH.
  - Load / store: alu_b_sel=1, next state MEM.
  - FENCE / SYSTEM: treated as NOP; pc_we=1, pc_sel=0, next state FETCH.
- Misalignment check in EXECUTE for loads and stores: a halfword access with addr_lo[0]=1, or a word access with addr_lo≠0, goes to TRAP with illegal=1.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for stores.
  - mem_wstrb: SB = 0001<<addr_lo, SH = 0011<<addr_lo, SW = 1111.
  - On mem_ready, a load goes to WB with rf_wsel=1. A store takes pc_we=1, pc_sel=0 and goes to FETCH.
- WB: rf_we = rg_we & (rd_addr≠0); pc_we=1 with pc_sel as set above; next state FETCH.
- TRAP: halted=1, all enables 0, mem_req=0. The block stays in TRAP until reset.
- retired increments by 1 on every cycle where pc_we=1. It wraps from 0xFFFFFFFF to 0.

## Timing
- With zero-wait memory (mem_ready high in the first request cycle), cycles per instruction are:
  - branch and FENCE/SYSTEM: 3
  - ALU, LUI, AUIPC, JAL, JALR and store: 4
  - load: 5
- Each memory wait cycle adds 1 cycle.
- mem_ready is sampled only while mem_req=1; it is ignored in all other states.
- Wait counter: reset to 0 on entry to FETCH or MEM and incremented each cycle mem_req=1 without mem_ready. When it reaches MEM_TIMEOUT, the next state is TRAP with illegal=1. mem_ready arriving in that same cycle wins and completes the access normally.
- mem_req, mem_we, mem_addr_sel and mem_wstrb stay stable from assertion until the mem_ready cycle inclusive.
- Reset asserted mid-access drops mem_req immediately (asynchronously). After reset deasserts, mem_req rises in the first cycle (state FETCH).

## Test plan
- ADDI x1,x0,5 with zero-wait memory → state sequence 0,1,2,4,0; rf_we=1 with rf_wsel=0 in WB; pc_we in cycle 4; retired=1.
- BEQ taken, then not taken → pc_we in EXECUTE with pc_sel=1, then pc_sel=0; 3 cycles each; rf_we never set.
- SB with addr_lo=2 and mem_ready delayed 3 cycles → mem_we=1 and mem_wstrb=0100 held for 4 cycles; pc_we on the mem_ready cycle.
- LW with addr_lo=1 → TRAP in the cycle after EXECUTE; illegal=1, halted=1, mem_req stays 0 thereafter.
- Opcode 0x7F → TRAP from DECODE; retired unchanged.
- mem_ready held low with MEM_TIMEOUT=4 → TRAP after 4 request cycles.
- Reset pulsed mid-MEM → all outputs 0 while reset is high; then FETCH with retired=0.
- ADD with rd=x0 → rf_we=0 in WB.

Source files
------------

// File: rtl/rv32i_control_fsm_if.sv
// Shared memory-port bundle between the control sequencer and the memory.
//   master (sequencer): drives mem_req, mem_we, mem_addr_sel, mem_wstrb; samples mem_ready
//   slave  (memory)   : samples the request fields; drives mem_ready
interface rv32i_control_fsm_if;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic [3:0] mem_wstrb;
    logic       mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr_sel,
        output mem_wstrb,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr_sel,
        input  mem_wstrb,
        output mem_ready
    );
endinterface

// File: rtl/rv32i_control_fsm.sv
// Multi-cycle control sequencer for a von Neumann RV32I core.
// Steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB, arbitrates
// the single shared memory port, drives all datapath selects/enables, traps on
// illegal opcodes, misaligned loads/stores and memory timeouts, and counts
// retired instructions.
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   opCode/funct3/rg_we/rd_addr   decoder fields of the current IR
//   branch_taken, addr_lo ALU compare result and low address bits
//   mem                   shared memory port (master side)
//   ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel, rf_we, rf_wsel  datapath controls
//   illegal, halted, retired, state   status / debug
module rv32i_control_fsm #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [6:0]                 opCode,
    input  logic [2:0]                 funct3,
    input  logic                       rg_we,
    input  logic [4:0]                 rd_addr,
    input  logic                       branch_taken,
    input  logic [1:0]                 addr_lo,
    rv32i_control_fsm_if.master        mem,
    output logic                       ir_we,
    output logic                       pc_we,
    output logic [1:0]                 pc_sel,
    output logic                       alu_a_sel,
    output logic                       alu_b_sel,
    output logic                       rf_we,
    output logic [1:0]                 rf_wsel,
    output logic                       illegal,
    output logic                       halted,
    output logic [31:0]                retired,
    output logic [2:0]                 state
);

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4,
        TRAP    = 3'd5
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] wait_cnt;

    logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store;
    logic is_imm, is_reg, is_nop, known_op, misaligned, timeout_hit;
    logic [3:0] store_strb;
    logic [1:0] wb_pc_sel;
    logic [1:0] wb_rf_wsel;
    logic       req;

    assign is_lui    = (opCode == OP_LUI);
    assign is_auipc  = (opCode == OP_AUIPC);
    assign is_jal    = (opCode == OP_JAL);
    assign is_jalr   = (opCode == OP_JALR);
    assign is_branch = (opCode == OP_BRANCH);
    assign is_load   = (opCode == OP_LOAD);
    assign is_store  = (opCode == OP_STORE);
    assign is_imm    = (opCode == OP_IMM);
    assign is_reg    = (opCode == OP_REG);
    assign is_nop    = (opCode == OP_FENCE) || (opCode == OP_SYSTEM);
    assign known_op  = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load
                     | is_store | is_imm | is_reg | is_nop;

    // funct3[1:0]: 00 byte, 01 halfword, 1x word
    assign misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0])
                      || (funct3[1] && (addr_lo != 2'b00));

    // Final state of a wait: the access still failing on the MEM_TIMEOUT-th cycle
    assign timeout_hit = (wait_cnt == 8'(MEM_TIMEOUT - 1));

    always_comb begin
        case (funct3[1:0])
            2'b00:   store_strb = 4'b0001 << addr_lo;
            2'b01:   store_strb = 4'b0011 << addr_lo;
            default: store_strb = 4'b1111;
        endcase
        wb_pc_sel  = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
        wb_rf_wsel = is_lui ? 2'd3 : ((is_jal | is_jalr) ? 2'd2 : (is_load ? 2'd1 : 2'd0));
    end

    // Outputs: purely combinational from state and inputs, forced to 0 in reset
    always_comb begin
        req              = 1'b0;
        mem.mem_we       = 1'b0;
        mem.mem_addr_sel = 1'b0;
        mem.mem_wstrb    = '0;
        ir_we            = 1'b0;
        pc_we            = 1'b0;
        pc_sel           = 2'd0;
        alu_a_sel        = 1'b0;
        alu_b_sel        = 1'b0;
        rf_we            = 1'b0;
        rf_wsel          = 2'd0;
        halted           = 1'b0;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    req   = 1'b1;
                    ir_we = mem.mem_ready;
                end
                EXECUTE: begin
                    alu_a_sel = is_auipc;
                    alu_b_sel = is_lui | is_auipc | is_imm | is_load | is_store | is_jalr;
                    if (is_branch) begin
                        pc_we  = 1'b1;
                        pc_sel = branch_taken ? 2'd1 : 2'd0;
                    end else if (is_nop) begin
                        pc_we = 1'b1;
                    end
                end
                MEM: begin
                    req              = 1'b1;
                    mem.mem_addr_sel = 1'b1;
                    alu_b_sel        = 1'b1;
                    if (is_store) begin
                        mem.mem_we    = 1'b1;
                        mem.mem_wstrb = store_strb;
                        pc_we         = mem.mem_ready;
                    end
                end
                WB: begin
                    alu_a_sel = is_auipc;
                    alu_b_sel = is_lui | is_auipc | is_imm | is_jalr;
                    rf_we     = rg_we && (rd_addr != 5'd0);
                    rf_wsel   = wb_rf_wsel;
                    pc_we     = 1'b1;
                    pc_sel    = wb_pc_sel;
                end
                TRAP:    halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign mem.mem_req = req;
    assign state       = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   state_d = mem.mem_ready ? DECODE : (timeout_hit ? TRAP : FETCH);
            DECODE:  state_d = known_op ? EXECUTE : TRAP;
            EXECUTE: begin
                if (is_branch || is_nop)
                    state_d = FETCH;
                else if (is_load || is_store)
                    state_d = misaligned ? TRAP : MEM;
                else if (is_lui || is_auipc || is_jal || is_jalr || is_imm || is_reg)
                    state_d = WB;
                else
                    state_d = TRAP;
            end
            MEM: begin
                if (mem.mem_ready)
                    state_d = is_store ? FETCH : WB;
                else if (timeout_hit)
                    state_d = TRAP;
            end
            WB:      state_d = FETCH;
            default: state_d = TRAP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= FETCH;
            wait_cnt <= '0;
            retired  <= '0;
            illegal  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == TRAP)
                illegal <= 1'b1;
            // Counter clears whenever no request is stalled, so every FETCH/MEM entry starts at 0
            if (req && !mem.mem_ready)
                wait_cnt <= wait_cnt + 8'd1;
            else
                wait_cnt <= '0;
            if (pc_we)
                retired <= retired + 32'd1;
        end
    end

endmodule
